hoop_round_ctrl: RTL and testbench

//  Parametrised round controller for the hoop game. Counts down a fixed-length round in seconds.

---
 rtl/hoop_pkg.sv | 32 +++
 rtl/hoop_round_debounce.sv | 44 ++++
 rtl/hoop_round_ctrl.sv | 108 ++++++++++
 tb/tb_hoop_round_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hoop_pkg.sv
// hoop_pkg: shared types and helpers for the hoop round controller.
package hoop_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    OVER    = 2'd2
  } state_t;

  localparam int TIME_W = 8;

  // prescaler width for a given clock rate, at least 1 bit
  function automatic int presc_w(input int hz);
    return (hz > 1) ? $clog2(hz) : 1;
  endfunction

  // stability counter width, able to hold the full debounce count
  function automatic int db_w(input int cyc);
    return (cyc > 0) ? $clog2(cyc + 1) : 1;
  endfunction

  // saturating add of a small increment to a w-bit score
  function automatic logic [31:0] sat_add(input logic [31:0] score, input logic [1:0] inc,
                                          input int w);
    logic [32:0] sum;
    logic [32:0] mx;
    mx  = (33'd1 << w) - 33'd1;
    sum = {1'b0, score} + 33'(inc);
    return (sum > mx) ? mx[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/hoop_round_debounce.sv
// hoop_debounce: 2-FF synchroniser, stability counter and rising-edge basket pulse
// for one hoop switch.
module hoop_debounce
  import hoop_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic basket
);

  localparam int CW = db_w(DEBOUNCE_CYC);

  logic          s1, s2, level, level_d;
  logic [CW-1:0] cnt;

  // synchronise, then accept the new level once it has differed for DEBOUNCE_CYC cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_d <= level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign basket = level & ~level_d;

endmodule

// File: rtl/hoop_round_ctrl.sv
// hoop_round_ctrl: round timer FSM, one-second prescaler and per-channel saturating
// scores fed by debounced hoop switches.
// Optional feature macro: HOOP_DOUBLE_PTS_EN (double points in the final DOUBLE_WINDOW seconds).
module hoop_round_ctrl
  import hoop_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int ROUND_SEC     = 10,
  parameter int NUM_CH        = 2,
  parameter int SCORE_W       = 8,
  parameter int DEBOUNCE_CYC  = 500_000,
  parameter int DOUBLE_WINDOW = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_CH-1:0]         hoop_in,
  output logic [TIME_W-1:0]         time_left,
  output logic [NUM_CH*SCORE_W-1:0] scores,
  output logic                      running,
  output logic                      game_over,
  output logic                      round_done,
  output logic                      sec_tick
);

  localparam int PW = presc_w(CLK_HZ);

`ifdef HOOP_DOUBLE_PTS_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  state_t        state, state_nx;
  logic [PW-1:0] presc;
  logic          tick, go, dbl;
  logic [1:0]    inc;

  assign tick = (state == RUNNING) && (presc == PW'(CLK_HZ - 1));
  // start only counts outside a running round
  assign go   = start && (state != RUNNING);
  assign dbl  = DBL_EN && (time_left <= TIME_W'(DOUBLE_WINDOW));
  assign inc  = dbl ? 2'd2 : 2'd1;

  assign running   = (state == RUNNING);
  assign game_over = (state == OVER);

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state: the final tick ends the round regardless of start
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUNNING;
      RUNNING: if (tick && time_left == TIME_W'(1)) state_nx = OVER;
      OVER:    if (start) state_nx = RUNNING;
      default: state_nx = IDLE;
    endcase
  end

  // prescaler, seconds countdown and registered pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc      <= '0;
      time_left  <= TIME_W'(ROUND_SEC);
      sec_tick   <= 1'b0;
      round_done <= 1'b0;
    end else begin
      sec_tick   <= tick;
      round_done <= tick && (time_left == TIME_W'(1));
      if (go) begin
        presc     <= '0;
        time_left <= TIME_W'(ROUND_SEC);
      end else if (tick) begin
        presc     <= '0;
        time_left <= time_left - TIME_W'(1);
      end else if (state == RUNNING) begin
        presc <= presc + PW'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic               basket;
    logic [SCORE_W-1:0] score;

    hoop_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clock  (clock),
      .reset  (reset),
      .raw    (hoop_in[k]),
      .basket (basket)
    );

    // score clears on start and only accumulates while running
    always_ff @(posedge clock or posedge reset) begin
      if (reset)                               score <= '0;
      else if (go)                             score <= '0;
      else if (state == RUNNING && basket)     score <= SCORE_W'(sat_add(32'(score), inc, SCORE_W));
    end

    assign scores[k*SCORE_W +: SCORE_W] = score;
  end

endmodule

// File: tb/tb_hoop_round_ctrl.sv
// tb_hoop_round_ctrl: directed and random stimulus against a cycle-count reference model.
module tb_hoop_round_ctrl;

  localparam int HZ  = 10;
  localparam int RS  = 3;
  localparam int NC  = 2;
  localparam int SW  = 4;
  localparam int SW1 = 1;
  localparam int DB  = 4;
  localparam int DW  = 1;

  logic            clock, reset, start;
  logic [NC-1:0]   hoop;
  logic [7:0]      time_left, time1;
  logic [NC*SW-1:0]  scores;
  logic [NC*SW1-1:0] scores1;
  logic running, game_over, round_done, sec_tick;
  logic running1, game_over1, round_done1, sec_tick1;

  hoop_round_ctrl #(.CLK_HZ(HZ), .ROUND_SEC(RS), .NUM_CH(NC), .SCORE_W(SW),
                    .DEBOUNCE_CYC(DB), .DOUBLE_WINDOW(DW)) u_dut (
    .clock(clock), .reset(reset), .start(start), .hoop_in(hoop),
    .time_left(time_left), .scores(scores), .running(running),
    .game_over(game_over), .round_done(round_done), .sec_tick(sec_tick));

  // narrow-score copy so saturation is reachable inside a 30-cycle round
  hoop_round_ctrl #(.CLK_HZ(HZ), .ROUND_SEC(RS), .NUM_CH(NC), .SCORE_W(SW1),
                    .DEBOUNCE_CYC(DB), .DOUBLE_WINDOW(DW)) u_sat (
    .clock(clock), .reset(reset), .start(start), .hoop_in(hoop),
    .time_left(time1), .scores(scores1), .running(running1),
    .game_over(game_over1), .round_done(round_done1), .sec_tick(sec_tick1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input int obs, input int want);
    n_chk++;
    if (obs != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  // reference model: phase 0 idle, 1 in round, 2 round over
  int m_phase, m_elapsed, m_time;
  bit m_tick, m_done;
  int m_sc  [NC];
  int m_sc1 [NC];
  bit m_lvl [NC];
  bit m_cred[NC];
  bit hist  [NC][DB+2];

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_time = RS; m_tick = 0; m_done = 0;
    for (int c = 0; c < NC; c++) begin
      m_sc[c] = 0; m_sc1[c] = 0; m_lvl[c] = 0; m_cred[c] = 0;
      for (int j = 0; j < DB + 2; j++) hist[c][j] = 0;
    end
  endtask

  function automatic int minv(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    int  inc;
    bit  same;
    m_tick = 0; m_done = 0;
    if (m_phase == 1) begin
      for (int c = 0; c < NC; c++) if (m_cred[c]) begin
        inc = 1;
`ifdef HOOP_DOUBLE_PTS_EN
        if (m_time <= DW) inc = 2;
`endif
        m_sc[c]  = minv(m_sc[c] + inc, (1 << SW) - 1);
        m_sc1[c] = minv(m_sc1[c] + inc, (1 << SW1) - 1);
      end
      m_elapsed++;
      if (m_elapsed % HZ == 0) begin
        m_tick = 1;
        m_time = RS - m_elapsed / HZ;
        if (m_time == 0) begin m_phase = 2; m_done = 1; end
      end
    end else if (start) begin
      m_phase = 1; m_elapsed = 0; m_time = RS;
      for (int c = 0; c < NC; c++) begin m_sc[c] = 0; m_sc1[c] = 0; end
    end
    // a level is accepted once DB consecutive raw samples, seen through the
    // two-stage synchroniser, agree and differ from the current level
    for (int c = 0; c < NC; c++) begin
      for (int j = DB + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
      hist[c][0] = hoop[c];
      m_cred[c] = 0;
      same = 1;
      for (int j = 2; j <= DB + 1; j++) if (hist[c][j] != hist[c][2]) same = 0;
      if (same && hist[c][2] != m_lvl[c]) begin
        m_lvl[c]  = hist[c][2];
        m_cred[c] = hist[c][2];
      end
    end
  endtask

  task automatic compare_all();
    chk("time_left",  int'(time_left),  m_time);
    chk("running",    int'(running),    int'(m_phase == 1));
    chk("game_over",  int'(game_over),  int'(m_phase == 2));
    chk("round_done", int'(round_done), int'(m_done));
    chk("sec_tick",   int'(sec_tick),   int'(m_tick));
    chk("sat_time",   int'(time1),      m_time);
    chk("sat_done",   int'(round_done1), int'(m_done));
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("score%0d", c),     int'(scores[c*SW +: SW]),    m_sc[c]);
      chk($sformatf("sat_score%0d", c), int'(scores1[c*SW1 +: SW1]), m_sc1[c]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_over();
    int n;
    n = 0;
    while (!game_over && n < 40) begin step(); n++; end
    chk("wait_over", int'(game_over), 1);
  endtask

  int ticks, dones;
  int seg[NC];

  initial begin
    reset = 1'b1; start = 1'b0; hoop = '0;
    model_reset();
    #12;
    compare_all();
    chk("rst_time", int'(time_left), RS);
    reset = 1'b0;
    repeat (3) step();

    // full round timing
    pulse_start();
    chk("run_rise", int'(running), 1);
    ticks = 0; dones = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      ticks += int'(sec_tick);
      dones += int'(round_done);
    end
    chk("tick_cnt", ticks, 3);
    chk("done_cnt", dones, 1);
    chk("over_hold", int'(game_over), 1);

    // bouncing input yields one basket
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      hoop[0] = ((i / 2) % 2 == 0);
      step();
    end
    hoop[0] = 1'b1;
    repeat (8) step();
    chk("bounce_score", int'(scores[SW-1:0]), 1);
    wait_over();
    hoop = '0;
    repeat (6) step();

    // fast pulses on both channels, narrow copy saturates
    pulse_start();
    for (int i = 0; i < 28; i++) begin
      hoop = ((i / 4) % 2 == 0) ? 2'b11 : 2'b00;
      step();
    end
    hoop = '0;
    wait_over();
    chk("sat_ch0", int'(scores1[0]), 1);
    chk("fast_ch1_nz", int'(scores[SW +: SW] != 0), 1);
    repeat (6) step();

    // basket on the final tick counts, one cycle later does not
    pulse_start();
    for (int k = 1; k <= 40; k++) begin
      hoop[0] = (k >= 24 && k <= 34);
      hoop[1] = (k >= 25 && k <= 34);
      step();
      if (k == 30) chk("final_tick_basket", int'(scores[SW-1:0]), 1);
      if (k == 31) chk("late_basket", int'(scores[SW +: SW]), 0);
    end
    pulse_start();
    chk("restart_time", int'(time_left), RS);
    chk("restart_score", int'(scores), 0);

    // reset mid-round
    repeat (14) step();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("midrst_run", int'(running), 0);
    @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;
    repeat (2) step();

    // start during a round is ignored
    pulse_start();
    repeat (5) step();
    pulse_start();
    repeat (6) step();
    chk("start_ignored", int'(time_left), 2);
    wait_over();

    // random play
    for (int c = 0; c < NC; c++) seg[c] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NC; c++) begin
        if (seg[c] == 0) begin
          hoop[c] = 1'($urandom_range(0, 1));
          seg[c]  = $urandom_range(1, 10);
        end
        seg[c]--;
      end
      start = ($urandom_range(0, 19) == 0);
      step();
    end
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
